trigger_barrier: RTL and testbench
==================================

# trigger_barrier

Network-level coordinator for a group of `NUM_TRIGGERS` actor triggers. It sits directly upstream of every trigger instance and does two things:
- Reduces the per-trigger `sleep`/`sync_exec`/`sync_wait` status into the shared `all_sleep`/`all_sync`/`all_sync_wait` inputs that each trigger consumes.
- Owns the host-facing `ap_start`/`ap_done` handshake: fans out start, collects per-trigger completion, and reports sync-round and cycle statistics for the run.

## Interface
- `NUM_TRIGGERS`, 4, number of attached triggers (≥1)
- `CNT_W`, 32, width of statistics counters
- `ap_clk` in 1 — clock
- `ap_rst_n` in 1 — synchronous, active-low reset
- `ap_start` in 1 — host start request
- `ap_done` out 1 — one-cycle pulse, run complete
- `ap_ready` out 1 — equal to `ap_done`
- `ap_idle` out 1 — high in IDLE
- `trig_start` out NUM_TRIGGERS — per-trigger `ap_start`
- `trig_done` in NUM_TRIGGERS — per-trigger `ap_done`
- `trig_sleep` in NUM_TRIGGERS — per-trigger `sleep`
- `trig_sync_exec` in NUM_TRIGGERS — per-trigger `sync_exec`
- `trig_sync_wait` in NUM_TRIGGERS — per-trigger `sync_wait`
- `all_sleep` out 1 — every trigger in SLEEP
- `all_sync` out 1 — every trigger in SYNC_EXEC or SYNC_WAIT
- `all_sync_wait` out 1 — every trigger in SYNC_WAIT
- `sync_rounds` out CNT_W — completed sync barriers in current/last run
- `run_cycles` out CNT_W — cycles spent in RUN in current/last run

## Operation
- Network FSM states: `NET_IDLE` → `NET_START` → `NET_RUN` → `NET_DONE` → `NET_IDLE`.
- `NET_IDLE`
  - `ap_idle`=1.
  - If `ap_start`=1, go to `NET_START`, and clear `done_mask`, `sync_rounds` and `run_cycles` to 0.
- `NET_START`
  - `trig_start` is all ones for exactly this one cycle.
  - Next state is always `NET_RUN`.
- `NET_RUN`
  - Register update: `done_mask <= done_mask | trig_done`.
  - `run_cycles` increments every cycle.
  - `sync_rounds` increments in each cycle where `all_sync`=1 and `all_sync_wait`=0 (a round that continues).
  - Go to `NET_DONE` when `(done_mask | trig_done)` is all ones.
- `NET_DONE`
  - `ap_done`=`ap_ready`=1 for this one cycle; next state is `NET_IDLE`.
- Reductions:
  - `all_sleep` = `&trig_sleep`.
  - `all_sync` = `&(trig_sync_exec | trig_sync_wait)`.
  - `all_sync_wait` = `&trig_sync_wait`.
  - All three are combinational and forced to 0 outside `NET_RUN`.
- Counters saturate at all ones; they do not wrap.
- `ap_start` outside `NET_IDLE` is ignored (no queuing).
- `trig_done` outside `NET_RUN` is ignored.
- With `NUM_TRIGGERS`=1, the reductions equal the single trigger's bits.

## Timing
- Reset values: state `NET_IDLE`, `ap_idle`=1, `ap_done`=`ap_ready`=0, `trig_start`=0, `all_*`=0, `done_mask`=0, `sync_rounds`=0, `run_cycles`=0.
- Start latency:
  - `ap_start` sampled at edge N.
  - `trig_start` is high during cycle N+1.
  - The FSM is in `NET_RUN` from N+2.
- Reduction outputs have zero-cycle latency (same cycle as the inputs). This is required because triggers evaluate `all_*` in their own next-state logic; a registered, stale barrier signal would release a trigger twice.
- Done latency: last `trig_done` bit at edge M → `ap_done` high in cycle M+1 → `ap_idle` high at M+2.
- Simultaneous `trig_done` on all bits in one cycle: a single transition to `NET_DONE`.
- Reset asserted mid-run: all state returns to reset values at the next edge. Triggers are reset by the same `ap_rst_n`.
- `ap_start` held high through `NET_DONE`: the FSM goes to `NET_IDLE`, then restarts on the following cycle.

## Structure
- Add `net_state_t` (`NET_IDLE`, `NET_START`, `NET_RUN`, `NET_DONE`) to the shared `TriggerTypes` package, alongside the existing trigger state/mode types.
- Single module, no sub-modules; the reductions are inline vector reductions.

## Test plan
- Reset, then idle:
  - `ap_rst_n`=0 for 3 cycles, then 1 → `ap_idle`=1, all other outputs 0, `sync_rounds`=`run_cycles`=0.
- Start pulse, N=4:
  - `ap_start`=1 at cycle 5 → `trig_start`=4'b1111 only in cycle 6; `ap_idle`=0 from cycle 6.
  - A second `ap_start` at cycle 8 is ignored.
- Reductions:
  - In RUN, `trig_sleep`=4'b1110 → `all_sleep`=0; `trig_sleep`=4'b1111 → `all_sleep`=1 in the same cycle.
  - `trig_sync_exec`=4'b0011 with `trig_sync_wait`=4'b1100 → `all_sync`=1, `all_sync_wait`=0, `sync_rounds`+1.
  - Outside RUN, all-ones inputs → all `all_*` outputs 0.
- Staggered done:
  - `trig_done` bits 0, 1, 2, 3 asserted one per cycle at cycles 20–23 → `ap_done`=`ap_ready`=1 only in cycle 24; `ap_idle`=1 at 25; `run_cycles` frozen.
- Reset mid-run:
  - Deassert `ap_rst_n` during RUN with `done_mask`=4'b0101 → next cycle in IDLE with `done_mask`=0.
  - A new start requires all four `trig_done` bits again.
- Saturation:
  - `CNT_W`=4, 20 continuing sync rounds → `sync_rounds`=15, no wrap.

Source files
------------

// File: rtl/trigger_barrier_pkg.sv
// TriggerTypes: shared type definitions for the actor trigger network.
// Holds the per-trigger state/mode encodings used by trigger instances and
// the network-level coordinator state used by trigger_barrier.
package TriggerTypes;

  // Per-trigger FSM states.
  typedef enum logic [2:0] {
    TRIG_IDLE,
    TRIG_EXEC,
    TRIG_SLEEP,
    TRIG_SYNC_EXEC,
    TRIG_SYNC_WAIT,
    TRIG_DONE
  } trig_state_t;

  // Per-trigger firing mode.
  typedef enum logic [1:0] {
    TRIG_MODE_FREE,
    TRIG_MODE_SYNC,
    TRIG_MODE_ONESHOT
  } trig_mode_t;

  // Network coordinator states.
  typedef enum logic [1:0] {
    NET_IDLE,
    NET_START,
    NET_RUN,
    NET_DONE
  } net_state_t;

endpackage

// File: rtl/trigger_barrier.sv
// trigger_barrier: coordinator for a group of NUM_TRIGGERS actor triggers.
// Reduces per-trigger sleep/sync status into the shared all_* barrier
// signals, and owns the host ap_start/ap_done handshake with run statistics.
//
// Ports:
//   ap_clk, ap_rst_n          clock, synchronous active-low reset
//   ap_start                  host start request (ignored unless idle)
//   ap_done/ap_ready          one-cycle completion pulse
//   ap_idle                   high while idle
//   trig_start                per-trigger start, all ones for one cycle
//   trig_done                 per-trigger completion (sampled only in RUN)
//   trig_sleep/_sync_exec/_sync_wait  per-trigger status
//   all_sleep/all_sync/all_sync_wait  combinational reductions (RUN only)
//   sync_rounds, run_cycles   saturating statistics for current/last run
module trigger_barrier
  import TriggerTypes::*;
#(
  parameter int unsigned NUM_TRIGGERS = 4,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    ap_start,
  output logic                    ap_done,
  output logic                    ap_ready,
  output logic                    ap_idle,
  output logic [NUM_TRIGGERS-1:0] trig_start,
  input  logic [NUM_TRIGGERS-1:0] trig_done,
  input  logic [NUM_TRIGGERS-1:0] trig_sleep,
  input  logic [NUM_TRIGGERS-1:0] trig_sync_exec,
  input  logic [NUM_TRIGGERS-1:0] trig_sync_wait,
  output logic                    all_sleep,
  output logic                    all_sync,
  output logic                    all_sync_wait,
  output logic [CNT_W-1:0]        sync_rounds,
  output logic [CNT_W-1:0]        run_cycles
);

  net_state_t              state, state_nxt;
  logic [NUM_TRIGGERS-1:0] done_mask;
  logic [NUM_TRIGGERS-1:0] done_acc;

  // Includes this cycle's trig_done so the last completion is seen without
  // waiting for done_mask to register it.
  assign done_acc = done_mask | trig_done;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state       <= NET_IDLE;
      done_mask   <= '0;
      sync_rounds <= '0;
      run_cycles  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        NET_IDLE: begin
          if (ap_start) begin
            done_mask   <= '0;
            sync_rounds <= '0;
            run_cycles  <= '0;
          end
        end
        NET_RUN: begin
          done_mask <= done_acc;
          if (run_cycles != '1)
            run_cycles <= run_cycles + CNT_W'(1);
          if (all_sync && !all_sync_wait && (sync_rounds != '1))
            sync_rounds <= sync_rounds + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt     = state;
    ap_idle       = 1'b0;
    ap_done       = 1'b0;
    trig_start    = '0;
    all_sleep     = 1'b0;
    all_sync      = 1'b0;
    all_sync_wait = 1'b0;
    case (state)
      NET_IDLE: begin
        ap_idle = 1'b1;
        if (ap_start)
          state_nxt = NET_START;
      end
      NET_START: begin
        trig_start = '1;
        state_nxt  = NET_RUN;
      end
      NET_RUN: begin
        // Zero-latency reductions: triggers consume these in their own
        // next-state logic, so a registered copy would be one cycle stale.
        all_sleep     = &trig_sleep;
        all_sync      = &(trig_sync_exec | trig_sync_wait);
        all_sync_wait = &trig_sync_wait;
        if (&done_acc)
          state_nxt = NET_DONE;
      end
      NET_DONE: begin
        ap_done   = 1'b1;
        state_nxt = NET_IDLE;
      end
      default: state_nxt = NET_IDLE;
    endcase
  end

  assign ap_ready = ap_done;

endmodule

// File: tb/tb_trigger_barrier.sv
module tb_trigger_barrier;

  localparam int unsigned N = 4;

  logic         ap_clk = 1'b0;
  logic         ap_rst_n;
  logic         ap_start;
  logic [N-1:0] trig_done, trig_sleep, trig_sync_exec, trig_sync_wait;

  logic         ap_done, ap_ready, ap_idle;
  logic [N-1:0] trig_start;
  logic         all_sleep, all_sync, all_sync_wait;
  logic [31:0]  sync_rounds, run_cycles;

  logic         s_ap_done, s_ap_ready, s_ap_idle;
  logic [N-1:0] s_trig_start;
  logic         s_all_sleep, s_all_sync, s_all_sync_wait;
  logic [3:0]   s_sync_rounds, s_run_cycles;

  always #5 ap_clk = ~ap_clk;

  trigger_barrier #(.NUM_TRIGGERS(N), .CNT_W(32)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
    .ap_done(ap_done), .ap_ready(ap_ready), .ap_idle(ap_idle),
    .trig_start(trig_start), .trig_done(trig_done), .trig_sleep(trig_sleep),
    .trig_sync_exec(trig_sync_exec), .trig_sync_wait(trig_sync_wait),
    .all_sleep(all_sleep), .all_sync(all_sync), .all_sync_wait(all_sync_wait),
    .sync_rounds(sync_rounds), .run_cycles(run_cycles)
  );

  trigger_barrier #(.NUM_TRIGGERS(N), .CNT_W(4)) dut_s (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
    .ap_done(s_ap_done), .ap_ready(s_ap_ready), .ap_idle(s_ap_idle),
    .trig_start(s_trig_start), .trig_done(trig_done), .trig_sleep(trig_sleep),
    .trig_sync_exec(trig_sync_exec), .trig_sync_wait(trig_sync_wait),
    .all_sleep(s_all_sleep), .all_sync(s_all_sync), .all_sync_wait(s_all_sync_wait),
    .sync_rounds(s_sync_rounds), .run_cycles(s_run_cycles)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: run phase plus set of completions seen and unbounded
  // event counts; saturation is applied only when comparing.
  typedef enum {M_IDLE, M_START, M_RUN, M_DONE} mphase_t;
  mphase_t      m_phase = M_IDLE;
  logic [N-1:0] m_seen = '0;
  int unsigned  m_rounds = 0, m_cycles = 0;

  function automatic int unsigned sat(input int unsigned x, input int unsigned w);
    int unsigned mx = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 1);
    return (x > mx) ? mx : x;
  endfunction

  task automatic drive(input bit rn, input bit st, input logic [N-1:0] dn,
                       input logic [N-1:0] sl, input logic [N-1:0] ex, input logic [N-1:0] wt);
    ap_rst_n = rn; ap_start = st; trig_done = dn;
    trig_sleep = sl; trig_sync_exec = ex; trig_sync_wait = wt;
  endtask

  task automatic model_check();
    bit run = (m_phase == M_RUN);
    bit e_sl = run && (trig_sleep == '1);
    bit e_sy = run && ((trig_sync_exec | trig_sync_wait) == '1);
    bit e_sw = run && (trig_sync_wait == '1);
    logic [N-1:0] e_ts = (m_phase == M_START) ? '1 : '0;
    chk("idle", ap_idle, m_phase == M_IDLE);
    chk("done", ap_done, m_phase == M_DONE);
    chk("ready", ap_ready, m_phase == M_DONE);
    chk("trig_start", trig_start, e_ts);
    chk("all_sleep", all_sleep, e_sl);
    chk("all_sync", all_sync, e_sy);
    chk("all_sync_wait", all_sync_wait, e_sw);
    chk("sync_rounds", sync_rounds, sat(m_rounds, 32));
    chk("run_cycles", run_cycles, sat(m_cycles, 32));
    chk("s_idle", s_ap_idle, m_phase == M_IDLE);
    chk("s_done", s_ap_done, m_phase == M_DONE);
    chk("s_all_sync", s_all_sync, e_sy);
    chk("s_sync_rounds", s_sync_rounds, sat(m_rounds, 4));
    chk("s_run_cycles", s_run_cycles, sat(m_cycles, 4));
  endtask

  task automatic advance();
    bit cont = ((trig_sync_exec | trig_sync_wait) == '1) && (trig_sync_wait != '1);
    @(posedge ap_clk);
    if (!ap_rst_n) begin
      m_phase = M_IDLE; m_seen = '0; m_rounds = 0; m_cycles = 0;
    end else begin
      case (m_phase)
        M_IDLE: if (ap_start) begin
          m_phase = M_START; m_seen = '0; m_rounds = 0; m_cycles = 0;
        end
        M_START: m_phase = M_RUN;
        M_RUN: begin
          m_seen |= trig_done;
          m_cycles++;
          if (cont) m_rounds++;
          if (m_seen == '1) m_phase = M_DONE;
        end
        M_DONE: m_phase = M_IDLE;
      endcase
    end
    #1;
  endtask

  task automatic cycle(input bit rn, input bit st, input logic [N-1:0] dn,
                       input logic [N-1:0] sl, input logic [N-1:0] ex, input logic [N-1:0] wt);
    drive(rn, st, dn, sl, ex, wt);
    @(negedge ap_clk);
    model_check();
    advance();
  endtask

  typedef struct {
    bit rn, st;
    logic [N-1:0] dn, sl, ex, wt;
    bit e_idle, e_done, e_ts, e_sl, e_sy, e_sw;
  } vec_t;

  function automatic vec_t v(bit rn, bit st, logic [N-1:0] dn, logic [N-1:0] sl,
                             logic [N-1:0] ex, logic [N-1:0] wt,
                             bit ei, bit ed, bit ets, bit esl, bit esy, bit esw);
    vec_t r;
    r.rn = rn; r.st = st; r.dn = dn; r.sl = sl; r.ex = ex; r.wt = wt;
    r.e_idle = ei; r.e_done = ed; r.e_ts = ets; r.e_sl = esl; r.e_sy = esy; r.e_sw = esw;
    return r;
  endfunction

  vec_t tbl[$];

  initial begin
    //          rn st dn    sl    ex    wt     idl dn ts sl sy sw
    tbl.push_back(v(1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 0, 0, 0, 0)); // reset state
    tbl.push_back(v(1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 0, 0, 0, 0)); // start sampled
    tbl.push_back(v(1, 0, 4'hF, 4'hF, 4'hF, 4'hF, 0, 0, 1, 0, 0, 0)); // START: done ignored
    tbl.push_back(v(1, 1, 4'h0, 4'hE, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0)); // start ignored, 1110
    tbl.push_back(v(1, 0, 4'h0, 4'hF, 4'h0, 4'h0, 0, 0, 0, 1, 0, 0)); // all sleep
    tbl.push_back(v(1, 0, 4'h0, 4'h0, 4'h3, 4'hC, 0, 0, 0, 0, 1, 0)); // continuing round
    tbl.push_back(v(1, 0, 4'h0, 4'h0, 4'h0, 4'hF, 0, 0, 0, 0, 1, 1)); // all waiting
    tbl.push_back(v(1, 0, 4'h1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0)); // staggered done
    tbl.push_back(v(1, 0, 4'h2, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 4'h4, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 4'h8, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 4'hF, 4'hF, 4'hF, 4'hF, 0, 1, 0, 0, 0, 0)); // DONE, all_* forced 0
    tbl.push_back(v(1, 0, 4'hF, 4'hF, 4'hF, 4'hF, 1, 0, 0, 0, 0, 0)); // IDLE, all_* forced 0
    tbl.push_back(v(1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 4'hF, 4'hF, 4'hF, 4'hF, 0, 0, 1, 0, 0, 0));
    tbl.push_back(v(1, 0, 4'h5, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0)); // mask 0101
    tbl.push_back(v(0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0)); // reset mid-run
    tbl.push_back(v(1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 0, 0, 0, 0)); // back in IDLE
    tbl.push_back(v(1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(v(1, 0, 4'hB, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0)); // old 0101 must be gone
    tbl.push_back(v(1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 4'h4, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 1, 0, 0, 0, 0)); // start held in DONE
    tbl.push_back(v(1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 1, 0, 0, 0)); // restart
    tbl.push_back(v(1, 0, 4'hF, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0)); // simultaneous done
    tbl.push_back(v(1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 0, 0, 0, 0));

    drive(0, 0, '0, '0, '0, '0);
    repeat (3) @(posedge ap_clk);
    #1;

    foreach (tbl[i]) begin
      drive(tbl[i].rn, tbl[i].st, tbl[i].dn, tbl[i].sl, tbl[i].ex, tbl[i].wt);
      @(negedge ap_clk);
      model_check();
      chk($sformatf("tbl%0d_idle", i), ap_idle, tbl[i].e_idle);
      chk($sformatf("tbl%0d_done", i), ap_done, tbl[i].e_done);
      chk($sformatf("tbl%0d_ready", i), ap_ready, tbl[i].e_done);
      chk($sformatf("tbl%0d_tstart", i), trig_start, tbl[i].e_ts ? 4'hF : 4'h0);
      chk($sformatf("tbl%0d_all_sleep", i), all_sleep, tbl[i].e_sl);
      chk($sformatf("tbl%0d_all_sync", i), all_sync, tbl[i].e_sy);
      chk($sformatf("tbl%0d_all_wait", i), all_sync_wait, tbl[i].e_sw);
      advance();
    end

    // Saturation: 20 continuing rounds, 4-bit counters stop at 15.
    cycle(1, 1, '0, '0, '0, '0);
    cycle(1, 0, '0, '0, '0, '0);
    for (int i = 0; i < 20; i++) cycle(1, 0, '0, '0, 4'h3, 4'hC);
    drive(1, 0, '0, '0, '0, '0);
    @(negedge ap_clk);
    chk("sat_small_rounds", s_sync_rounds, 15);
    chk("sat_small_cycles", s_run_cycles, 15);
    chk("sat_wide_rounds", sync_rounds, 20);
    chk("sat_wide_cycles", run_cycles, 20);
    advance();
    cycle(1, 0, 4'hF, '0, '0, '0);
    cycle(1, 0, '0, '0, '0, '0);
    cycle(1, 0, '0, '0, '0, '0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] dn, sl, ex, wt;
      for (int b = 0; b < N; b++) begin
        dn[b] = ($urandom_range(0, 3) == 0);
        sl[b] = ($urandom_range(0, 3) != 0);
        ex[b] = $urandom_range(0, 1);
        wt[b] = ($urandom_range(0, 2) != 0);
      end
      cycle(($urandom_range(0, 79) != 0), ($urandom_range(0, 3) == 0), dn, sl, ex, wt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
